systolic_edge_feeder: RTL and testbench

- Drives one edge (left/A or top/B) of the 2-D systolic PE array.
- Accepts one K-step vector per beat over valid/ready and applies a triangular skew: lane i is delayed i extra cycles.
- Frames each tile: pulses clear_all before the first beat and pulses done once the last skewed element has left the edge.
- One instance per array edge; the controller starts both instances together.

---
 rtl/systolic_edge_feeder.sv | 182 ++++++++++++++++++
 tb/tb_systolic_edge_feeder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_edge_feeder.sv
// -----------------------------------------------------------------------------
// systolic_edge_feeder
//
// Feeds one edge (left/A or top/B) of a 2-D systolic PE array. Accepts one
// K-step vector per beat over valid/ready and applies a triangular skew so
// lane i reaches the array i cycles later than lane 0. Each tile is framed by
// a one-cycle clear_all pulse before the first beat and a one-cycle done pulse
// after the last skewed element has left the edge.
//
// Parameters:
//   LANES    - number of array rows/columns fed
//   DATA_W_P - signed element width (matches DATA_W of the backbone package)
//   K_W      - width of the K-length field
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   start, k_len     - tile start pulse and beat count, sampled in IDLE only
//   busy, done       - high outside IDLE / one-cycle tile-end pulse
//   s_valid, s_ready - input beat handshake
//   s_data           - LANES packed elements, lane i at [i*DATA_W_P +: DATA_W_P]
//   clear_all        - accumulator clear to the array
//   edge_data        - skewed elements to the array edge, same packing
//   edge_valid       - per-lane valid, skewed identically to data
//   stall_cycles     - (FEEDER_STALL_CNT_EN only) saturating count of FEED
//                      cycles that had s_ready=1 and s_valid=0
//
// Optional feature macro: FEEDER_STALL_CNT_EN
// -----------------------------------------------------------------------------
module systolic_edge_feeder #(
  parameter int LANES    = 4,
  parameter int DATA_W_P = 8,
  parameter int K_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [K_W-1:0]            k_len,
  output logic                      busy,
  output logic                      done,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*DATA_W_P-1:0] s_data,
  output logic                      clear_all,
  output logic [LANES*DATA_W_P-1:0] edge_data,
  output logic [LANES-1:0]          edge_valid
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int FW = $clog2(LANES + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [K_W-1:0] remaining_r;
  logic [FW-1:0]  flush_cnt_r;
  logic           accept_s;

  // s_ready is a registered decode of the FEED state, so this is the beat handshake
  assign accept_s = s_valid && s_ready;

  // Next-state logic for the tile framing FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_CLEAR;
        else       state_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (remaining_r != {K_W{1'b0}}) state_s = ST_FEED;
        else                            state_s = ST_DONE;
      end
      ST_FEED: begin
        if (accept_s && (remaining_r == K_W'(1))) state_s = ST_FLUSH;
        else                                      state_s = ST_FEED;
      end
      ST_FLUSH: begin
        // LANES flush cycles let the deepest lane drain its last element
        if (flush_cnt_r == FW'(LANES - 1)) state_s = ST_DONE;
        else                               state_s = ST_FLUSH;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and outputs registered from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy      <= 1'b0;
      clear_all <= 1'b0;
      s_ready   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy      <= (state_s != ST_IDLE);
      clear_all <= (state_s == ST_CLEAR);
      s_ready   <= (state_s == ST_FEED);
      done      <= (state_s == ST_DONE);
    end
  end

  // Remaining-beat and flush counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_r <= {K_W{1'b0}};
      flush_cnt_r <= FW'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) remaining_r <= k_len;
        end
        ST_FEED: begin
          if (accept_s) remaining_r <= remaining_r - K_W'(1);
        end
        default: begin
          remaining_r <= remaining_r;
        end
      endcase
      if (state_r == ST_FLUSH) flush_cnt_r <= flush_cnt_r + FW'(1);
      else                     flush_cnt_r <= FW'(0);
    end
  end

  // Triangular skew: lane i is a free-running shift register of depth i+1.
  // Non-accept cycles inject zero data so holes never carry stale values.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W_P-1:0] sr_data  [0:i];
    logic                sr_valid [0:i];

    // Per-lane shift register, shifts every cycle regardless of state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) begin
          sr_data[j]  <= {DATA_W_P{1'b0}};
          sr_valid[j] <= 1'b0;
        end
      end else begin
        sr_data[0]  <= accept_s ? s_data[i*DATA_W_P +: DATA_W_P] : {DATA_W_P{1'b0}};
        sr_valid[0] <= accept_s;
        for (int j = 1; j <= i; j++) begin
          sr_data[j]  <= sr_data[j-1];
          sr_valid[j] <= sr_valid[j-1];
        end
      end
    end

    assign edge_data[i*DATA_W_P +: DATA_W_P] = sr_data[i];
    assign edge_valid[i]                     = sr_valid[i];
  end

`ifdef FEEDER_STALL_CNT_EN
  // Saturating stall counter, cleared at the start of each tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
    end else if (state_r == ST_CLEAR) begin
      stall_cycles <= 32'd0;
    end else if (s_ready && !s_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_edge_feeder
//
// Self-checking bench for systolic_edge_feeder (LANES=4, DATA_W_P=8, K_W=16).
// A directed table covers the basic tile, hand-written sequences cover stalls,
// k_len=0, ignored starts, back-to-back tiles, mid-tile reset and negative
// data, and randomized tiles are checked against a timeline model: accepts are
// logged per cycle and lane r at cycle c must show the beat accepted at c-1-r.
// -----------------------------------------------------------------------------
module tb_systolic_edge_feeder;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int KW    = 16;
  localparam int HMAX  = 8192;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [KW-1:0]         k_len;
  logic                  busy;
  logic                  done;
  logic                  s_valid;
  logic                  s_ready;
  logic [LANES*DW-1:0]   s_data;
  logic                  clear_all;
  logic [LANES*DW-1:0]   edge_data;
  logic [LANES-1:0]      edge_valid;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0]           stall_cycles;
`endif

  always #5 clk = ~clk;

  systolic_edge_feeder #(.LANES(LANES), .DATA_W_P(DW), .K_W(KW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .clear_all  (clear_all),
    .edge_data  (edge_data),
    .edge_valid (edge_valid)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Timeline model of the current tile
  bit                  m_active;
  int                  m_start;
  int                  m_k;
  int                  m_acc;
  int                  m_done;
  bit                  acc_flag [HMAX];
  logic [LANES*DW-1:0] acc_data [HMAX];
  logic [31:0]         m_stall;

  // Outputs seen in the most recent step
  logic                snap_busy, snap_clear, snap_ready, snap_done;
  logic [LANES-1:0]    snap_valid;
  logic [LANES*DW-1:0] snap_data;

  typedef struct {
    logic                start;
    logic [KW-1:0]       k_len;
    logic                s_valid;
    logic [LANES*DW-1:0] s_data;
    logic                e_busy;
    logic                e_clear;
    logic                e_ready;
    logic                e_done;
    logic [LANES-1:0]    e_valid;
    logic [LANES*DW-1:0] e_data;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_start  = 0;
    m_k      = 0;
    m_acc    = 0;
    m_done   = -1;
    m_stall  = 32'd0;
    for (int i = 0; i < HMAX; i++) begin
      acc_flag[i] = 1'b0;
      acc_data[i] = '0;
    end
  endtask

  function automatic bit tile_over();
    return (m_done >= 0) && (cyc > m_done);
  endfunction

  // One clock cycle: compare at negedge, update model, advance past posedge
  task automatic step();
    logic                e_busy, e_clear, e_ready, e_done, acc;
    logic [LANES-1:0]    e_valid;
    logic [LANES*DW-1:0] e_data;
    int                  idx;
    @(negedge clk);
    e_busy  = m_active && (cyc > m_start) && ((m_done < 0) || (cyc <= m_done));
    e_clear = m_active && (cyc == m_start + 1);
    e_ready = m_active && (cyc >= m_start + 2) && (m_acc < m_k);
    e_done  = m_active && (cyc == m_done);
    e_valid = '0;
    e_data  = '0;
    for (int r = 0; r < LANES; r++) begin
      idx = cyc - 1 - r;
      if (idx >= 0 && acc_flag[idx]) begin
        e_valid[r]          = 1'b1;
        e_data[r*DW +: DW]  = acc_data[idx][r*DW +: DW];
      end
    end
    check("busy",       busy,       e_busy);
    check("clear_all",  clear_all,  e_clear);
    check("s_ready",    s_ready,    e_ready);
    check("done",       done,       e_done);
    check("edge_valid", edge_valid, e_valid);
    check("edge_data",  edge_data,  e_data);
`ifdef FEEDER_STALL_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
    snap_busy  = busy;
    snap_clear = clear_all;
    snap_ready = s_ready;
    snap_done  = done;
    snap_valid = edge_valid;
    snap_data  = edge_data;
    acc = e_ready && s_valid;
    acc_flag[cyc] = acc;
    acc_data[cyc] = s_data;
    if (acc) begin
      m_acc++;
      if (m_acc == m_k) m_done = cyc + LANES + 1;
    end
    if (e_clear) m_stall = 32'd0;
    else if (e_ready && !s_valid && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    if (start && !e_busy) begin
      m_active = 1'b1;
      m_start  = cyc;
      m_k      = int'(k_len);
      m_acc    = 0;
      m_done   = (k_len == '0) ? cyc + 2 : -1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, done_at2, clr_cnt, rdy_cnt, n;
    bit fin;

    tbl[0]  = '{1'b1, 16'd3, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 16'd7, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0000};
    tbl[2]  = '{1'b0, 16'd7, 1'b1, 32'h0302_0100, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000};
    tbl[3]  = '{1'b0, 16'd0, 1'b1, 32'h0D0C_0B0A, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 32'h0000_0000};
    tbl[4]  = '{1'b0, 16'd0, 1'b1, 32'h1716_1514, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 32'h0000_010A};
    tbl[5]  = '{1'b0, 16'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 32'h0002_0B14};
    tbl[6]  = '{1'b0, 16'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 4'hE, 32'h030C_1500};
    tbl[7]  = '{1'b0, 16'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 32'h0D16_0000};
    tbl[8]  = '{1'b0, 16'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 32'h1700_0000};
    tbl[9]  = '{1'b0, 16'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0000_0000};
    tbl[10] = '{1'b0, 16'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000};

    // Reset state
    rst_n = 1'b0; start = 1'b0; k_len = '0; s_valid = 1'b0; s_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  busy, 1'b0);
    check("rst_done",  done, 1'b0);
    check("rst_ready", s_ready, 1'b0);
    check("rst_clear", clear_all, 1'b0);
    check("rst_valid", edge_valid, 4'h0);
    check("rst_data",  edge_data, 32'h0);
    rst_n = 1'b1;
    cyc   = 0;

    // Directed basic tile from the table
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start; k_len = tbl[i].k_len;
      s_valid = tbl[i].s_valid; s_data = tbl[i].s_data;
      step();
      check("tbl_busy",  snap_busy,  tbl[i].e_busy);
      check("tbl_clear", snap_clear, tbl[i].e_clear);
      check("tbl_ready", snap_ready, tbl[i].e_ready);
      check("tbl_done",  snap_done,  tbl[i].e_done);
      check("tbl_valid", snap_valid, tbl[i].e_valid);
      check("tbl_data",  snap_data,  tbl[i].e_data);
    end

    // One-cycle stall after the first accept: done one cycle later
    done_at = -1;
    for (int i = 0; i < 14; i++) begin
      start = (i == 0); k_len = 16'd3; s_valid = (i != 3);
      s_data = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
      step();
      if (snap_done && done_at < 0) done_at = i;
    end
    check("stall_done_lat", done_at, 10);
`ifdef FEEDER_STALL_CNT_EN
    check("stall_count", stall_cycles, 32'd1);
`endif

    // k_len = 0: clear then done, no ready, no valid
    clr_cnt = 0; rdy_cnt = 0; done_at = -1;
    for (int i = 0; i < 6; i++) begin
      start = (i == 0); k_len = 16'd0; s_valid = 1'b1; s_data = 32'hA5A5_A5A5;
      step();
      if (snap_clear) clr_cnt++;
      if (snap_ready || snap_valid != 4'h0) rdy_cnt++;
      if (snap_done && done_at < 0) done_at = i;
    end
    check("k0_clear_cnt", clr_cnt, 1);
    check("k0_ready_valid", rdy_cnt, 0);
    check("k0_done_at", done_at, 2);

    // start while busy is ignored; back-to-back tile right after done
    done_at = -1; done_at2 = -1;
    for (int i = 0; i < 22; i++) begin
      start = (i == 0) || (i == 3) || (i == 11);
      k_len = (i == 0) ? 16'd4 : ((i == 11) ? 16'd2 : 16'd1);
      s_valid = 1'b1; s_data = $urandom;
      step();
      if (snap_done && i < 11) done_at = i;
      if (snap_done && i >= 11) done_at2 = i;
    end
    check("busy_start_done", done_at, 10);
    check("b2b_done", done_at2, 19);

    // Reset mid-FEED with two beats in flight
    for (int i = 0; i < 4; i++) begin
      start = (i == 0); k_len = 16'd5; s_valid = 1'b1; s_data = $urandom;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  busy, 1'b0);
    check("mid_rst_ready", s_ready, 1'b0);
    check("mid_rst_valid", edge_valid, 4'h0);
    check("mid_rst_data",  edge_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc++;
    for (int i = 0; i < 8; i++) begin
      start = 1'b0; s_valid = 1'b1; s_data = $urandom;
      step();
    end

    // Negative element on lane 2
    for (int i = 0; i < 9; i++) begin
      start = (i == 0); k_len = 16'd1; s_valid = 1'b1;
      s_data = (i == 2) ? 32'h3380_2211 : 32'h5555_5555;
      step();
      if (i == 5) begin
        check("neg_lane2", snap_data[23:16], 8'h80);
        check("neg_valid2", snap_valid[2], 1'b1);
        check("neg_hole_lane0", snap_data[7:0], 8'h00);
      end
    end

    // Randomized tiles
    for (int t = 0; t < 40; t++) begin
      start = 1'b1; k_len = 16'($urandom_range(0, 6));
      s_valid = ($urandom_range(0, 9) < 7); s_data = $urandom;
      step();
      n = 0;
      fin = 1'b0;
      while (n < 60 && !fin) begin
        start = ($urandom_range(0, 9) == 0);
        k_len = 16'($urandom_range(0, 9));
        s_valid = ($urandom_range(0, 9) < 7);
        s_data = $urandom;
        step();
        n++;
        fin = tile_over();
      end
      check("rand_tile_end", fin, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        start = 1'b0; s_valid = 1'b1; s_data = $urandom;
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
